mult_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the shift-add multiplier. It accepts one unsigned product per handshake and converts it with the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It presents packed BCD digits for the display stage.

---
 rtl/mult_bcd_converter.sv | 118 +++++++++++
 tb/tb_mult_bcd_converter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_bcd_converter.sv
// mult_bcd_converter
// Sequential binary-to-BCD converter (shift-and-add-3). It accepts one unsigned
// product per in_valid/in_ready handshake and consumes one input bit per clock.
// The result is presented on out_bcd with an out_valid/out_ready handshake.
// Digits that do not fit in DIGITS nibbles are dropped, so out_bcd is
// in_data mod 10^DIGITS.
//
// Optional build macro: MULT_BCD_CONVERTER_OVF_EN
//   defined     : ovf is a sticky flag for bits lost off the top digit
//   not defined : ovf is tied low and no overflow logic is built
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for a product, in_ready high
// S_SHIFT | one double-dabble step per clock, IN_W steps in total
// S_DONE  | result held on out_bcd, out_valid high until out_ready
module mult_bcd_converter #(
  parameter int IN_W   = 9,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  ovf,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state;
  logic [IN_W-1:0]       bin;
  logic [BCD_W-1:0]      bcd;
  logic [CNT_W-1:0]      cnt;
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W+IN_W-1:0] shifted;

  // Add-3 correction: each digit >= 5 gets +3 within its own nibble.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit falls off the end of the truncated shift.
  assign shifted = {bcd_adj, bin} << 1;

  // Sequencer: load on accept, shift IN_W times, hold until downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            bin   <= in_data;
            bcd   <= '0;
            cnt   <= CNT_W'(IN_W);
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {bcd, bin} <= shifted;
          cnt        <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MULT_BCD_CONVERTER_OVF_EN
  logic ovf_r;

  // Sticky overflow: cleared at accept, collects every bit lost off the top digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      ovf_r <= 1'b0;
    end else if (state == S_SHIFT) begin
      ovf_r <= ovf_r | bcd_adj[BCD_W-1];
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_SHIFT);
  assign out_valid = (state == S_DONE);
  assign out_bcd   = bcd;

endmodule

// File: tb/tb_mult_bcd_converter.sv
// Bench for mult_bcd_converter: a transaction/timing reference model checked
// every cycle against the default-parameter instance, directed vectors with
// literal expectations, and a DIGITS=2 instance for the truncation/overflow case.
module tb_mult_bcd_converter;

  localparam int IN_W   = 9;
  localparam int DIGITS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_bcd;
  logic        ovf;
  logic        busy;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [8:0]  in_data2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [7:0]  out_bcd2;
  logic        ovf2;
  logic        busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .ovf(ovf), .busy(busy)
  );

  mult_bcd_converter #(.IN_W(9), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_bcd(out_bcd2), .ovf(ovf2), .busy(busy2)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal digits by division, packed one per nibble, upper digits dropped.
  function automatic int to_bcd(input int v, input int d);
    int r = 0;
    int x = v;
    for (int i = 0; i < d; i++) begin
      r = r | ((x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int exp_ovf(input int v, input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
`ifdef MULT_BCD_CONVERTER_OVF_EN
    return (v >= p) ? 1 : 0;
`else
    return (p > 0 && v < 0) ? 1 : 0;
`endif
  endfunction

  // Reference model: a job is accepted at edge m_t, its result is visible
  // from IN_W edges later until the edge that sees out_ready.
  int cyc = 0;
  int m_t = 0;
  int m_val = 0;
  bit m_active = 1'b0;
  bit m_rst_seen = 1'b0;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    m_rst_seen <= rst;
    if (rst) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_val    <= int'(in_data);
        m_t      <= cyc + 1;
      end
    end else if ((cyc + 1 - m_t) > IN_W && out_ready) begin
      m_active <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("mdl_in_ready", int'(in_ready), int'(!m_active));
      check("mdl_busy", int'(busy), int'(m_active && (cyc - m_t) < IN_W));
      check("mdl_out_valid", int'(out_valid), int'(m_active && (cyc - m_t) >= IN_W));
      if (m_active && (cyc - m_t) >= IN_W) begin
        check("mdl_out_bcd", int'(out_bcd), to_bcd(m_val, DIGITS));
        check("mdl_ovf", int'(ovf), exp_ovf(m_val, DIGITS));
      end
      if (m_rst_seen) begin
        check("mdl_rst_bcd", int'(out_bcd), 0);
        check("mdl_rst_ovf", int'(ovf), 0);
      end
    end
  end

  task automatic accept(input int v);
    bit rdy;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = 9'(v);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    in_valid = 1'b0;
    in_data  = 9'h1AB;
    check("accept_timeout", int'(done), 1);
  endtask

  task automatic run_one(input string name, input int v, input int exp_bcd);
    int n = 0;
    int nb = 0;
    bit seen = 1'b0;
    accept(v);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        if (busy) nb++;
        n++;
      end
    end
    check({name, "_seen"}, int'(seen), 1);
    check({name, "_latency"}, n, 9);
    check({name, "_busy_cycles"}, nb, 9);
    check({name, "_bcd"}, int'(out_bcd), exp_bcd);
    check({name, "_ovf"}, int'(ovf), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    bit rdy;
    bit prev_ov;
    int rises;
    int last_rise;
    int k;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_bcd", int'(out_bcd), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    run_one("p32", 32, 12'h032);
    run_one("p0", 0, 12'h000);
    run_one("p511", 511, 12'h511);
    run_one("p225", 225, 12'h225);

    // Back-pressure: result held, new input ignored.
    out_ready = 1'b0;
    accept(99);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("bp_seen", int'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_bcd", int'(out_bcd), 12'h099);
      check("bp_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 9'd7;
      @(negedge clk);
    end
    check("bp_valid_end", int'(out_valid), 1);
    check("bp_bcd_end", int'(out_bcd), 12'h099);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_ready", int'(in_ready), 1);
    check("bp_release_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // Reset in the middle of a conversion.
    accept(200);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rmid_in_ready", int'(in_ready), 1);
    check("rmid_out_valid", int'(out_valid), 0);
    check("rmid_busy", int'(busy), 0);
    check("rmid_bcd", int'(out_bcd), 0);
    check("rmid_ovf", int'(ovf), 0);
    @(posedge clk);
    #1;
    run_one("p45", 45, 12'h045);

    // Throughput with in_valid and out_ready held high.
    in_valid  = 1'b1;
    in_data   = 9'd1;
    k         = 0;
    rises     = 0;
    last_rise = 0;
    prev_ov   = 1'b0;
    for (int c = 0; c < 80 && rises < 3; c++) begin
      @(negedge clk);
      rdy = in_ready;
      if (out_valid && !prev_ov) begin
        check("thru_val", int'(out_bcd), rises + 1);
        if (rises > 0) check("thru_gap", c - last_rise, IN_W + 2);
        last_rise = c;
        rises++;
      end
      prev_ov = out_valid;
      @(posedge clk);
      #1;
      if (rdy && in_valid) begin
        k++;
        if (k < 3) in_data = 9'(k + 1);
        else in_valid = 1'b0;
      end
    end
    check("thru_count", rises, 3);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // DIGITS=2 instance: truncation and overflow.
    for (int t = 0; t < 2; t++) begin
      int v;
      int eb;
      int eo;
      bit ok;
      v  = (t == 0) ? 144 : 99;
      eb = (t == 0) ? 8'h44 : 8'h99;
`ifdef MULT_BCD_CONVERTER_OVF_EN
      eo = (t == 0) ? 1 : 0;
`else
      eo = 0;
`endif
      in_valid2 = 1'b1;
      in_data2  = 9'(v);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        rdy = in_ready2;
        @(posedge clk);
        #1;
        if (rdy) ok = 1'b1;
      end
      in_valid2 = 1'b0;
      in_data2  = 9'h1FF;
      check("d2_accept", int'(ok), 1);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (out_valid2) seen = 1'b1;
      end
      check("d2_seen", int'(seen), 1);
      check("d2_bcd", int'(out_bcd2), eb);
      check("d2_ovf", int'(ovf2), eo);
      @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
